cnn_train_sequencer: RTL and testbench

CNN_TRAIN_SEQUENCER -- requirements
Module: cnn_train_sequencer

---
 rtl/cnn_train_sequencer.sv | 147 ++++++++++++++
 tb/tb_cnn_train_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cnn_train_sequencer.sv
// Training-run sequencer: forward stages, backprop join, batch/epoch advance.
// Optional stage watchdog with FAULT state enabled by CNN_SEQ_TIMEOUT_EN.
module cnn_train_sequencer #(
    parameter int unsigned NUM_EPOCHS     = 5,
    parameter int unsigned BATCH_SIZE     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       conv_done,
    input  logic       pool_done,
    input  logic       fc_done,
    input  logic       conv_bp_done,
    input  logic       pool_bp_done,
    input  logic       fc_bp_done,
    output logic       conv_enable,
    output logic       pool_enable,
    output logic       fc_enable,
    output logic       input_valid,
    output logic       error_latch,
    output logic [3:0] epoch_idx,
    output logic [7:0] batch_idx,
    output logic       busy,
    output logic       run_done,
    output logic       fault
);
    localparam int unsigned EPOCH_W = 4;
    localparam int unsigned BATCH_W = 8;

    if (NUM_EPOCHS < 1 || NUM_EPOCHS > 16 || BATCH_SIZE < 1 || BATCH_SIZE > 256 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("cnn_train_sequencer: illegal parameterisation");
    end

`ifdef CNN_SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_CONV, S_POOL, S_FC, S_BP, S_ADV, S_DONE, S_FAULT
    } state_t;
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] wdog, wdog_next;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_CONV, S_POOL, S_FC, S_BP, S_ADV, S_DONE
    } state_t;
`endif

    state_t               state, state_next;
    logic [EPOCH_W-1:0]   epoch_next;
    logic [BATCH_W-1:0]   batch_next;
    logic [2:0]           bp_flags, bp_flags_next;
    logic                 in_stage;

    // Next-state, counter and backprop-join logic
    always_comb begin
        state_next    = state;
        epoch_next    = epoch_idx;
        batch_next    = batch_idx;
        bp_flags_next = bp_flags;
        in_stage      = (state == S_CONV) || (state == S_POOL) ||
                        (state == S_FC)   || (state == S_BP);
        case (state)
            S_IDLE: if (start) begin
                state_next = S_CONV;
                epoch_next = '0;
                batch_next = '0;
            end
            S_CONV: if (conv_done) state_next = S_POOL;
            S_POOL: if (pool_done) state_next = S_FC;
            S_FC: if (fc_done) begin
                state_next    = S_BP;
                bp_flags_next = '0;
            end
            S_BP: begin
                // Dones sampled this cycle count, so the join can close in one cycle
                bp_flags_next = bp_flags | {conv_bp_done, pool_bp_done, fc_bp_done};
                if (&bp_flags_next) state_next = S_ADV;
            end
            S_ADV: begin
                if (batch_idx < BATCH_W'(BATCH_SIZE - 1)) begin
                    batch_next = batch_idx + BATCH_W'(1);
                    state_next = S_CONV;
                end else begin
                    batch_next = '0;
                    if (epoch_idx < EPOCH_W'(NUM_EPOCHS - 1)) begin
                        epoch_next = epoch_idx + EPOCH_W'(1);
                        state_next = S_CONV;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: if (!start) state_next = S_IDLE;
            default: state_next = state;
        endcase
`ifdef CNN_SEQ_TIMEOUT_EN
        if (in_stage && (wdog >= WDOG_W'(TIMEOUT_CYCLES - 1))) state_next = S_FAULT;
        wdog_next = (in_stage && (state_next == state)) ? wdog + WDOG_W'(1) : '0;
`endif
    end

    // State, counters and outputs, all registered from the next state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            epoch_idx   <= '0;
            batch_idx   <= '0;
            bp_flags    <= '0;
            conv_enable <= 1'b0;
            pool_enable <= 1'b0;
            fc_enable   <= 1'b0;
            input_valid <= 1'b0;
            error_latch <= 1'b0;
            busy        <= 1'b0;
            run_done    <= 1'b0;
        end else begin
            state       <= state_next;
            epoch_idx   <= epoch_next;
            batch_idx   <= batch_next;
            bp_flags    <= bp_flags_next;
            conv_enable <= (state_next == S_CONV);
            pool_enable <= (state_next == S_POOL);
            fc_enable   <= (state_next == S_FC);
            input_valid <= (state_next == S_CONV);
            error_latch <= (state_next == S_BP) && (state != S_BP);
            busy        <= (state_next == S_CONV) || (state_next == S_POOL) ||
                           (state_next == S_FC) || (state_next == S_BP) ||
                           (state_next == S_ADV);
            run_done    <= (state_next == S_DONE);
        end
    end

`ifdef CNN_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            wdog  <= '0;
            fault <= 1'b0;
        end else begin
            wdog  <= wdog_next;
            fault <= (state_next == S_FAULT);
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_train_sequencer.sv
// Scoreboard bench for cnn_train_sequencer (NUM_EPOCHS=2, BATCH_SIZE=3, TIMEOUT_CYCLES=10).
module tb_cnn_train_sequencer;
    logic       clk = 1'b0;
    logic       reset, start;
    logic       conv_done, pool_done, fc_done;
    logic       conv_bp_done, pool_bp_done, fc_bp_done;
    logic       conv_enable, pool_enable, fc_enable, input_valid, error_latch;
    logic [3:0] epoch_idx;
    logic [7:0] batch_idx;
    logic       busy, run_done, fault;

    int n_cmp = 0;
    int n_err = 0;
    logic [11:0] exp_q[$];

    cnn_train_sequencer #(.NUM_EPOCHS(2), .BATCH_SIZE(3), .TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start),
        .conv_done(conv_done), .pool_done(pool_done), .fc_done(fc_done),
        .conv_bp_done(conv_bp_done), .pool_bp_done(pool_bp_done), .fc_bp_done(fc_bp_done),
        .conv_enable(conv_enable), .pool_enable(pool_enable), .fc_enable(fc_enable),
        .input_valid(input_valid), .error_latch(error_latch),
        .epoch_idx(epoch_idx), .batch_idx(batch_idx),
        .busy(busy), .run_done(run_done), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: each error_latch pulse must match the next expected {epoch, batch}
    always @(negedge clk) begin
        if (reset) begin
            check("enables_exclusive", 32'(int'(conv_enable) + int'(pool_enable) + int'(fc_enable) <= 1), 32'd1);
            check("input_valid_eq_conv", 32'(input_valid), 32'(conv_enable));
            if (error_latch) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_error_latch", 32'({epoch_idx, batch_idx}), 32'hfff);
                end else begin
                    logic [11:0] e;
                    e = exp_q.pop_front();
                    check("sample_idx", 32'({epoch_idx, batch_idx}), 32'(e));
                end
            end
        end
    end

    function automatic logic sig(input int which);
        case (which)
            0: return conv_enable;
            1: return pool_enable;
            2: return fc_enable;
            3: return error_latch;
            default: return run_done;
        endcase
    endfunction

    // Bounded wait at negedge; an expired bound counts as a failure
    task automatic wait_sig(input int which);
        for (int i = 0; i < 200; i++) begin
            if (sig(which)) return;
            @(negedge clk);
        end
        check($sformatf("wait_timeout_%0d", which), 32'd0, 32'd1);
    endtask

    task automatic pulse_done(input int which);
        repeat (3) @(negedge clk);
        case (which)
            0: conv_done = 1'b1;
            1: pool_done = 1'b1;
            default: fc_done = 1'b1;
        endcase
        @(negedge clk);
        conv_done = 1'b0; pool_done = 1'b0; fc_done = 1'b0;
    endtask

    // mode 0: all bp dones together on BP cycle 2; 1: fc, conv, pool separately;
    // 2: all on the BP entry cycle.  stray=1 pulses pool_done while in CONV.
    task automatic do_sample(input int mode, input bit stray);
        wait_sig(0);
        if (stray) begin
            pool_done = 1'b1;
            @(negedge clk);
            pool_done = 1'b0;
            check("stray_conv_en", 32'(conv_enable), 32'd1);
            check("stray_pool_en", 32'(pool_enable), 32'd0);
        end
        pulse_done(0);
        wait_sig(1);
        pulse_done(1);
        wait_sig(2);
        pulse_done(2);
        wait_sig(3);
        if (mode == 1) begin
            @(negedge clk); fc_bp_done = 1'b1;
            @(negedge clk); fc_bp_done = 1'b0; conv_bp_done = 1'b1;
            @(negedge clk); conv_bp_done = 1'b0; pool_bp_done = 1'b1;
        end else begin
            if (mode == 0) @(negedge clk);
            conv_bp_done = 1'b1; pool_bp_done = 1'b1; fc_bp_done = 1'b1;
        end
        @(negedge clk);
        conv_bp_done = 1'b0; pool_bp_done = 1'b0; fc_bp_done = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0;
        conv_done = 1'b0; pool_done = 1'b0; fc_done = 1'b0;
        conv_bp_done = 1'b0; pool_bp_done = 1'b0; fc_bp_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_outputs", 32'({conv_enable, pool_enable, fc_enable, input_valid,
                                 error_latch, busy, run_done, fault}), 32'd0);
        check("rst_idx", 32'({epoch_idx, batch_idx}), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Full run: 2 epochs x 3 samples, start held high throughout
        exp_q.push_back(12'h000); exp_q.push_back(12'h001); exp_q.push_back(12'h002);
        exp_q.push_back(12'h100); exp_q.push_back(12'h101); exp_q.push_back(12'h102);
        start = 1'b1;
        do_sample(0, 1'b0);
        do_sample(1, 1'b0);
        do_sample(0, 1'b0);
        do_sample(2, 1'b0);
        do_sample(0, 1'b1);
        do_sample(1, 1'b0);
        wait_sig(4);
        check("done_idx", 32'({epoch_idx, batch_idx}), 32'h100);
        check("done_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        check("done_hold", 32'(run_done), 32'd1);
        check("no_restart", 32'(conv_enable), 32'd0);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("idle_after_done", 32'({run_done, busy}), 32'd0);
        check("queue_empty_run1", 32'(exp_q.size()), 32'd0);

        // Restart, then reset while in FC at batch 2
        exp_q.push_back(12'h000); exp_q.push_back(12'h001);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("restart_conv", 32'(conv_enable), 32'd1);
        check("restart_idx", 32'({epoch_idx, batch_idx}), 32'd0);
        do_sample(0, 1'b0);
        do_sample(2, 1'b0);
        wait_sig(0);
        pulse_done(0);
        wait_sig(1);
        pulse_done(1);
        wait_sig(2);
        check("fc_at_batch2", 32'(batch_idx), 32'd2);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rst_fc_en", 32'(fc_enable), 32'd0);
        check("rst_batch", 32'(batch_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("no_adv_after_rst", 32'({busy, batch_idx}), 32'd0);
        check("queue_empty_run2", 32'(exp_q.size()), 32'd0);

        // Watchdog: conv_done never returned
        start = 1'b1;
        wait_sig(0);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("wdog_before", 32'({conv_enable, fault}), 32'b10);
        @(negedge clk);
`ifdef CNN_SEQ_TIMEOUT_EN
        check("wdog_fault", 32'({fault, conv_enable, busy}), 32'b100);
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("fault_sticky", 32'({fault, conv_enable}), 32'b10);
`else
        check("no_wdog", 32'({fault, conv_enable, busy}), 32'b011);
        repeat (20) @(negedge clk);
        check("no_wdog_long", 32'({fault, conv_enable}), 32'b01);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
